// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues word-aligned fetch requests, tracks
// in-flight responses, queues returned instructions with their PCs, and
// flushes on branch redirects while discarding stale responses.
module fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk1,
  input  logic                       reset1,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [31:0]                imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_out,
  output logic [31:0]                inst_pc,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]      data_mem_q [DEPTH];
  logic [31:0]      pc_mem_q   [DEPTH];

  logic [CNT_W:0]   occupancy;
  logic             req_hs;
  logic             pop;
  logic             rsp_keep;
  logic             rsp_drop;
  logic [31:0]      redirect_aligned;

  // Entries already queued plus responses still owed; a request is only
  // issued when its response is guaranteed a free slot.
  assign occupancy        = {1'b0, count_q} + {1'b0, outst_q};
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  assign imem_req_valid = !reset1 && !redirect_valid
                          && (occupancy < (CNT_W+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = (count_q != '0) && !redirect_valid;
  assign inst_out       = (count_q != '0) ? data_mem_q[rd_ptr_q] : 32'h0;
  assign inst_pc        = (count_q != '0) ? pc_mem_q[rd_ptr_q] : 32'h0;
  assign fifo_count     = count_q;

  assign req_hs   = imem_req_valid && imem_req_ready;
  assign pop      = inst_valid && inst_ready;
  assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop_q == '0);
  assign rsp_drop = imem_rsp_valid && !redirect_valid && (drop_q != '0);

  // Next-state for PCs, in-flight/stale counters and FIFO pointers.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_valid) begin
      // Every response still owed after this cycle belongs to the old path,
      // so the stale count becomes exactly the remaining in-flight count.
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      outst_d    = outst_q - CNT_W'(imem_rsp_valid);
      drop_d     = outst_q - CNT_W'(imem_rsp_valid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_hs) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      outst_d = outst_q + CNT_W'(req_hs) - CNT_W'(imem_rsp_valid);
      if (rsp_drop) begin
        drop_d = drop_q - CNT_W'(1);
      end
      if (rsp_keep) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(rsp_keep) - CNT_W'(pop);
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage; contents are only visible through count_q, so no reset.
  always_ff @(posedge clk1) begin
    if (rsp_keep) begin
      data_mem_q[wr_ptr_q] <= imem_rsp_data;
      pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed vector table, hand-written corner
// sequences, and randomized traffic against an epoch-tagged reference model.
module tb_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CW       = $clog2(DEPTH + 1);

  logic          clk1 = 1'b0;
  logic          reset1;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [31:0]   imem_req_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst_out;
  logic [31:0]   inst_pc;
  logic [CW-1:0] fifo_count;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk1           (clk1),
    .reset1         (reset1),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .fifo_count     (fifo_count)
  );

  always #5 clk1 = ~clk1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  typedef struct { logic [31:0] addr; int epoch; int cyc; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  mreq_t       memq[$];
  ent_t        fq[$];
  int          epoch;
  int          cyc;
  logic [31:0] exp_req_pc;
  logic [31:0] req_log[$];
  logic [31:0] cons_log[$];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  task automatic do_reset();
    reset1         = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b0;
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fifo_count", 32'(fifo_count), 32'h0);
    @(posedge clk1); #1;
    reset1 = 1'b0;
    memq.delete();
    fq.delete();
    epoch      = 0;
    cyc        = 0;
    exp_req_pc = RESET_PC;
  endtask

  // One clock cycle: drive inputs, check outputs against model, advance model.
  task automatic step(input bit redir, input logic [31:0] rpc,
                      input int p_ir, input int p_rsp, input int p_rr);
    logic        e_rv, e_iv;
    logic [31:0] e_pc, e_out;
    mreq_t       m;
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = ($urandom_range(99) < p_ir);
    imem_req_ready = ($urandom_range(99) < p_rr);
    if (memq.size() > 0 && memq[0].cyc < cyc && $urandom_range(99) < p_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data_of(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    @(negedge clk1);
    e_rv  = !redir && ((fq.size() + memq.size()) < DEPTH);
    e_iv  = (fq.size() != 0) && !redir;
    e_pc  = (fq.size() != 0) ? fq[0].pc : 32'h0;
    e_out = (fq.size() != 0) ? fq[0].data : 32'h0;
    chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
    chk("req_addr", imem_req_addr, exp_req_pc);
    chk("inst_valid", 32'(inst_valid), 32'(e_iv));
    chk("inst_pc", inst_pc, e_pc);
    chk("inst_out", inst_out, e_out);
    chk("fifo_count", 32'(fifo_count), 32'(fq.size()));
    if (redir) begin
      if (imem_rsp_valid) void'(memq.pop_front());
      fq.delete();
      epoch++;
      exp_req_pc = {rpc[31:2], 2'b00};
    end else begin
      if (e_iv && inst_ready) begin
        cons_log.push_back(fq[0].pc);
        void'(fq.pop_front());
      end
      if (imem_rsp_valid) begin
        m = memq.pop_front();
        if (m.epoch == epoch) fq.push_back('{m.addr, data_of(m.addr)});
      end
      if (e_rv && imem_req_ready) begin
        memq.push_back('{exp_req_pc, epoch, cyc});
        req_log.push_back(exp_req_pc);
        exp_req_pc = exp_req_pc + 32'd4;
      end
      if (fq.size() > DEPTH) chk("fifo_overflow", 32'(fq.size()), 32'(DEPTH));
    end
    @(posedge clk1); #1;
    cyc++;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rsp_v;
    logic [31:0]   rsp_d;
    logic          redir;
    logic [31:0]   rpc;
    logic          e_rv;
    logic [31:0]   e_addr;
    logic          e_iv;
    logic [31:0]   e_pc;
    logic [31:0]   e_out;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int k;
    tbl[0] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 32'h0,  1'b0, 32'h0,  32'h0,   CW'(0)};
    tbl[1] = '{1'b1, 32'h100, 1'b0, 32'h0,  1'b1, 32'h4,  1'b0, 32'h0,  32'h0,   CW'(0)};
    tbl[2] = '{1'b1, 32'h104, 1'b0, 32'h0,  1'b1, 32'h8,  1'b1, 32'h0,  32'h100, CW'(1)};
    tbl[3] = '{1'b1, 32'h108, 1'b0, 32'h0,  1'b1, 32'hC,  1'b1, 32'h4,  32'h104, CW'(1)};
    tbl[4] = '{1'b1, 32'h10C, 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 32'h8,  32'h108, CW'(1)};
    tbl[5] = '{1'b1, 32'h110, 1'b1, 32'h43, 1'b0, 32'h14, 1'b0, 32'hC,  32'h10C, CW'(1)};
    tbl[6] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 32'h0,  32'h0,   CW'(0)};
    tbl[7] = '{1'b1, 32'h140, 1'b0, 32'h0,  1'b1, 32'h44, 1'b0, 32'h0,  32'h0,   CW'(0)};
    tbl[8] = '{1'b1, 32'h144, 1'b0, 32'h0,  1'b1, 32'h48, 1'b1, 32'h40, 32'h140, CW'(1)};

    // Table: in-order streaming with 1-cycle memory, then redirect to 0x43
    // colliding with a response.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      imem_rsp_valid = tbl[i].rsp_v;
      imem_rsp_data  = tbl[i].rsp_d;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      inst_ready     = 1'b1;
      imem_req_ready = 1'b1;
      @(negedge clk1);
      chk($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_rv));
      chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_inst_valid", i), 32'(inst_valid), 32'(tbl[i].e_iv));
      chk($sformatf("tbl%0d_inst_pc", i), inst_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_inst_out", i), inst_out, tbl[i].e_out);
      chk($sformatf("tbl%0d_fifo_count", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
      @(posedge clk1); #1;
    end

    // Backpressure: FIFO fills with exactly DEPTH requests, then resumes.
    do_reset();
    req_log.delete();
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 0, 100, 100);
    chk("bp_req_valid", 32'(imem_req_valid), 32'h0);
    chk("bp_fifo_count", 32'(fifo_count), 32'(DEPTH));
    chk("bp_num_reqs", 32'(req_log.size()), 32'd4);
    if (req_log.size() == 4) chk("bp_last_req", req_log[3], 32'hC);
    k = 0;
    while (req_log.size() < 5 && k < 20) begin
      step(1'b0, 32'h0, 100, 100, 100);
      k++;
    end
    chk("bp_resume_addr", (req_log.size() >= 5) ? req_log[4] : 32'hDEAD_BEEF, 32'h10);

    // Redirect with two requests (0x8, 0xC) in flight.
    do_reset();
    req_log.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 100, 100, 100);
    step(1'b0, 32'h0, 100, 0, 100);
    chk("rd2_inflight", 32'(memq.size()), 32'd2);
    step(1'b1, 32'h40, 100, 0, 100);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 0, 100, 100);
    chk("rd2_head_pc", inst_pc, 32'h40);
    chk("rd2_head_out", inst_out, 32'h140);

    // Redirect to the top of the address space wraps to zero.
    req_log.delete();
    cons_log.delete();
    step(1'b1, 32'hFFFF_FFFC, 100, 100, 100);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 100, 100, 100);
    chk("wrap_req0", (req_log.size() >= 2) ? req_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_req1", (req_log.size() >= 2) ? req_log[1] : 32'hDEAD_BEEF, 32'h0);
    chk("wrap_pc0", (cons_log.size() >= 2) ? cons_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_pc1", (cons_log.size() >= 2) ? cons_log[1] : 32'hDEAD_BEEF, 32'h0);

    // Reset mid-operation with queued entries and in-flight requests.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 0, 100, 100);
    step(1'b0, 32'h0, 0, 0, 100);
    chk("mid_fifo_count", 32'(fifo_count), 32'd2);
    chk("mid_inflight", 32'(memq.size()), 32'd2);
    do_reset();
    imem_req_ready = 1'b1;
    #1;
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'h1);
    chk("post_rst_req_addr", imem_req_addr, RESET_PC);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          rd;
      logic [31:0] rp;
      rd = ($urandom_range(99) < 4);
      rp = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      if ($urandom_range(499) == 0) do_reset();
      step(rd, rp, $urandom_range(100), $urandom_range(100), $urandom_range(100));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
